// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32I memory request at a time, validates it, performs a
// single-cycle access on the data-memory port and holds the response until it is consumed.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  resp_err_cause,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [1:0]  mem_byte_size,
  output logic        mem_sign_ext,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp, StErr} state_e;

  localparam logic [1:0] CauseNone     = 2'b00;
  localparam logic [1:0] CauseMisalign = 2'b01;
  localparam logic [1:0] CauseRange    = 2'b10;
  localparam logic [1:0] CauseFunct3   = 2'b11;
  localparam logic [31:0] MemLimit     = 32'(MEM_BYTES);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  cause_q, cause_d;

  logic        illegal, misaligned, out_of_range;
  logic [1:0]  req_cause;

  // Classification of the incoming request, highest priority first.
  always_comb begin
    if (req_we) begin
      illegal = req_funct3[2] | (req_funct3 == 3'b011);
    end else begin
      illegal = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
    end
    misaligned   = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                   ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
    out_of_range = (req_addr >= MemLimit);
    if (illegal)           req_cause = CauseFunct3;
    else if (misaligned)   req_cause = CauseMisalign;
    else if (out_of_range) req_cause = CauseRange;
    else                   req_cause = CauseNone;
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    rdata_d  = rdata_q;
    cause_d  = cause_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d     = req_we;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          rdata_d  = '0;
          cause_d  = req_cause;
          state_d  = (req_cause == CauseNone) ? StAccess : StErr;
        end
      end
      StAccess: begin
        rdata_d = we_q ? '0 : mem_read_data;
        state_d = StResp;
      end
      StResp, StErr: begin
        if (resp_ready) begin
          rdata_d = '0;
          cause_d = CauseNone;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready      = (state_q == StIdle);
    resp_valid     = (state_q == StResp) || (state_q == StErr);
    resp_err       = (state_q == StErr);
    resp_err_cause = cause_q;
    resp_rdata     = rdata_q;
    mem_address    = '0;
    mem_write_data = '0;
    mem_memwrite   = 1'b0;
    mem_memread    = 1'b0;
    mem_byte_size  = '0;
    mem_sign_ext   = 1'b0;
    if (state_q == StAccess) begin
      mem_address    = addr_q;
      mem_write_data = wdata_q;
      mem_byte_size  = funct3_q[1:0];
      mem_sign_ext   = ~funct3_q[2];
      // Gated by reset so a store caught by a reset edge never commits.
      mem_memwrite   = we_q & ~reset;
      mem_memread    = ~we_q & ~reset;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      rdata_q  <= '0;
      cause_q  <= CauseNone;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      rdata_q  <= rdata_d;
      cause_q  <= cause_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-addressed memory model on the mem_* port,
// reference byte array for expected data, scoreboard queue of expected responses.
module tb_load_store_unit;

  logic        clock, reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err_cause;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_memwrite, mem_memread, mem_sign_ext;
  logic [1:0]  mem_byte_size;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic [7:0] ref_mem [0:1023];

  load_store_unit #(.MEM_BYTES(1024)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_err_cause(resp_err_cause),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite),
    .mem_memread(mem_memread), .mem_byte_size(mem_byte_size), .mem_sign_ext(mem_sign_ext),
    .mem_read_data(mem_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data memory: little-endian, extends loads itself from byte_size/sign_ext.
  logic [7:0]  mem [0:1023];
  logic [9:0]  ma;
  logic [31:0] raw;
  always_comb begin
    ma  = mem_address[9:0];
    raw = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};
    case (mem_byte_size)
      2'b00:   mem_read_data = mem_sign_ext ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
      2'b01:   mem_read_data = mem_sign_ext ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
      default: mem_read_data = raw;
    endcase
  end

  always @(posedge clock) begin
    if (mem_memwrite) begin
      mem[ma] <= mem_write_data[7:0];
      if (mem_byte_size != 2'b00) mem[ma + 10'd1] <= mem_write_data[15:8];
      if (mem_byte_size == 2'b10) begin
        mem[ma + 10'd2] <= mem_write_data[23:16];
        mem[ma + 10'd3] <= mem_write_data[31:24];
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One full transaction; expected response comes from the reference array and the
  // cause given by the caller, and is compared when the DUT raises resp_valid.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [1:0] cause, input int hold,
                        input string name);
    exp_t        e, got;
    int          a, lat, rd, wr, exp_rd, exp_wr;
    logic [7:0]  b;
    logic [15:0] h;
    logic        addr_bad;
    logic [31:0] snap;
    a = int'(addr[9:0]);
    e.cause = cause;
    e.err   = (cause != 2'b00);
    e.rdata = '0;
    if (cause == 2'b00) begin
      if (we) begin
        ref_mem[a] = wdata[7:0];
        if (f3[1:0] != 2'b00) ref_mem[a+1] = wdata[15:8];
        if (f3[1:0] == 2'b10) begin
          ref_mem[a+2] = wdata[23:16];
          ref_mem[a+3] = wdata[31:24];
        end
      end else begin
        case (f3[1:0])
          2'b00: begin
            b = ref_mem[a];
            e.rdata = f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
          end
          2'b01: begin
            h = {ref_mem[a+1], ref_mem[a]};
            e.rdata = f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
          end
          default: e.rdata = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        endcase
      end
    end
    sb.push_back(e);

    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    @(posedge clock);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;

    rd = 0; wr = 0; addr_bad = 1'b0;
    for (lat = 1; lat <= 10; lat++) begin
      @(negedge clock);
      if (mem_memread) rd++;
      if (mem_memwrite) wr++;
      if ((mem_memread || mem_memwrite) && mem_address !== addr) addr_bad = 1'b1;
      if (resp_valid) break;
    end
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s resp_valid timeout: got %b want 1", name, resp_valid);
    end
    if (cause == 2'b00) begin
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("FAIL %s latency: got %0d want 2", name, lat);
      end
    end
    exp_rd = (cause == 2'b00 && !we) ? 1 : 0;
    exp_wr = (cause == 2'b00 && we) ? 1 : 0;
    checks++;
    if (rd !== exp_rd || wr !== exp_wr || addr_bad !== 1'b0) begin
      errors++;
      $display("FAIL %s mem strobes: got rd=%0d wr=%0d addr_bad=%b want rd=%0d wr=%0d addr_bad=0",
               name, rd, wr, addr_bad, exp_rd, exp_wr);
    end

    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty: got 0 entries want 1", name);
    end else begin
      got = '{rdata: resp_rdata, err: resp_err, cause: resp_err_cause};
      e = sb.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s response: got rdata=%h err=%b cause=%b want rdata=%h err=%b cause=%b",
                 name, got.rdata, got.err, got.cause, e.rdata, e.err, e.cause);
      end
    end

    snap = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== snap) begin
        errors++;
        $display("FAIL %s hold%0d: got valid=%b ready=%b rdata=%h want valid=1 ready=0 rdata=%h",
                 name, i, resp_valid, req_ready, resp_rdata, snap);
      end
    end

    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s release: got req_ready=%b resp_valid=%b want 1 0",
               name, req_ready, resp_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_err, resp_err_cause, mem_address,
         mem_write_data, mem_memwrite, mem_memread, mem_byte_size, mem_sign_ext} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b rdata=%h err=%b cause=%b addr=%h wr=%b rd=%b want 1 0 0 0 00 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err, resp_err_cause, mem_address,
               mem_memwrite, mem_memread);
    end
  endtask

  task automatic test_store_load();
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 2'b00, 0, "sw_0x10");
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 2'b00, 0, "lw_0x10");
  endtask

  task automatic test_extension();
    do_req(1'b1, 32'h20, 32'h000080F0, 3'b010, 2'b00, 0, "sw_0x20");
    do_req(1'b0, 32'h20, 32'h0, 3'b000, 2'b00, 0, "lb_0x20");
    do_req(1'b0, 32'h20, 32'h0, 3'b100, 2'b00, 0, "lbu_0x20");
    do_req(1'b0, 32'h20, 32'h0, 3'b001, 2'b00, 0, "lh_0x20");
    do_req(1'b0, 32'h20, 32'h0, 3'b101, 2'b00, 0, "lhu_0x20");
    do_req(1'b1, 32'h11, 32'hFFFFFF5A, 3'b000, 2'b00, 0, "sb_0x11");
    do_req(1'b1, 32'h12, 32'h0000C3A7, 3'b001, 2'b00, 0, "sh_0x12");
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 2'b00, 0, "lw_0x10_merged");
  endtask

  task automatic test_misaligned();
    do_req(1'b0, 32'h22, 32'h0, 3'b010, 2'b01, 0, "lw_0x22_misal");
    do_req(1'b1, 32'h21, 32'hFFFF1234, 3'b001, 2'b01, 0, "sh_0x21_misal");
    do_req(1'b0, 32'h20, 32'h0, 3'b010, 2'b00, 0, "lw_0x20_unchanged");
    do_req(1'b0, 32'h401, 32'h0, 3'b001, 2'b01, 0, "lh_0x401_prio");
  endtask

  task automatic test_range_funct3();
    do_req(1'b0, 32'h400, 32'h0, 3'b010, 2'b10, 0, "lw_0x400_range");
    do_req(1'b0, 32'h80000010, 32'h0, 3'b010, 2'b10, 0, "lw_nowrap_range");
    do_req(1'b1, 32'h3FC, 32'h11223344, 3'b010, 2'b00, 0, "sw_0x3fc_edge");
    do_req(1'b0, 32'h3FC, 32'h0, 3'b010, 2'b00, 0, "lw_0x3fc_edge");
    do_req(1'b0, 32'h10, 32'h0, 3'b011, 2'b11, 0, "load_f3_011");
    do_req(1'b0, 32'h401, 32'h0, 3'b111, 2'b11, 0, "load_f3_111_prio");
    do_req(1'b1, 32'h10, 32'h0, 3'b100, 2'b11, 0, "store_f3_100");
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 2'b00, 0, "lw_0x10_after_err");
  endtask

  task automatic test_backpressure();
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 2'b00, 5, "lw_backpressure");
    do_req(1'b1, 32'h24, 32'h0BADF00D, 3'b010, 2'b00, 3, "sw_backpressure");
  endtask

  task automatic test_reset_mid_op();
    do_req(1'b1, 32'h30, 32'hCAFEF00D, 3'b010, 2'b00, 0, "sw_0x30_prior");
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h12345678;
    req_funct3 = 3'b010;
    @(posedge clock);
    #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (mem_memwrite !== 1'b0) begin
      errors++;
      $display("FAIL rst_access_memwrite: got %b want 0", mem_memwrite);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_err, resp_err_cause, mem_address,
         mem_write_data, mem_memwrite, mem_memread, mem_byte_size, mem_sign_ext} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL rst_midop_state: got rdy=%b vld=%b rdata=%h err=%b cause=%b addr=%h wr=%b rd=%b want 1 0 0 0 00 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err, resp_err_cause, mem_address,
               mem_memwrite, mem_memread);
    end
    do_req(1'b0, 32'h30, 32'h0, 3'b010, 2'b00, 0, "lw_0x30_after_rst");

    // Pending response dropped by reset with resp_ready held low.
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30; req_funct3 = 3'b010;
    @(posedge clock);
    #1;
    req_valid = 1'b0; req_addr = '0; req_funct3 = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL pending_before_rst: got valid=%b rdata=%h want 1 cafef00d",
               resp_valid, resp_rdata);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL pending_discard: got valid=%b ready=%b rdata=%h want 0 1 0",
               resp_valid, req_ready, resp_rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_funct3 = '0; resp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_extension();
    test_misaligned();
    test_range_funct3();
    test_backpressure();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, giving the data-memory size in bytes; legal addresses are 0..MEM_BYTES-1.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  pipeline presents a memory request.
REQ-005 SHALL have port req_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-009 SHALL have port req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port resp_valid  output  1  response available.
REQ-011 SHALL have port resp_ready  input  1  pipeline consumes the response.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  misaligned, out-of-range or illegal-funct3 request.
REQ-014 SHALL have port resp_err_cause  output  2  00 none, 01 misaligned, 10 out of range, 11 illegal funct3.
REQ-015 SHALL have ports mem_address (output, 32), mem_write_data (output, 32), mem_memwrite (output, 1), mem_memread (output, 1), mem_byte_size (output, 2) and mem_sign_ext (output, 1); these drive the data-memory port.
REQ-016 SHALL have port mem_read_data  input  32  combinational read data from the data memory.

Function
REQ-017 SHALL implement the FSM states IDLE, ACCESS, RESP and ERR.
REQ-018 SHALL assert req_ready only in IDLE; the handshake is req_valid && req_ready.
REQ-019 SHALL register req_we, req_addr, req_wdata and req_funct3 on the handshake; the request signals are not used after acceptance.
REQ-020 SHALL classify each request on acceptance, in priority order:
- illegal funct3 (011, 110 or 111 for loads; funct3[2]=1 or funct3=011 for stores) -> ERR, cause 11;
- misaligned (H with addr[0]=1; W with addr[1:0]!=0) -> ERR, cause 01;
- addr >= MEM_BYTES -> ERR, cause 10;
- otherwise -> ACCESS.
REQ-021 In ACCESS, SHALL drive the memory port from the registered request:
- mem_address = the registered address;
- mem_write_data = the registered wdata;
- mem_byte_size = funct3[1:0];
- mem_sign_ext = ~funct3[2].
REQ-022 SHALL assert mem_memwrite for exactly one cycle (the ACCESS cycle) per store, and never otherwise.
REQ-023 SHALL assert mem_memread only in the ACCESS cycle of a load; at the end of that cycle it SHALL capture mem_read_data into resp_rdata.
REQ-024 SHALL transition ACCESS -> RESP unconditionally after one cycle; request-to-resp_valid latency is 2 cycles.
REQ-025 SHALL hold resp_valid high in RESP and ERR, with stable resp_rdata, resp_err and resp_err_cause, until resp_ready=1.
REQ-026 On resp_valid && resp_ready, SHALL return to IDLE; a new request is accepted no earlier than the following cycle (no back-to-back overlap).
REQ-027 SHALL never assert mem_memwrite or mem_memread in ERR; the memory contents are unchanged by an erroneous store.
REQ-028 Outside ACCESS, SHALL drive mem_memwrite=0, mem_memread=0 and mem_address, mem_write_data, mem_byte_size, mem_sign_ext all 0.
REQ-029 For stores, resp_rdata SHALL be 0 and resp_err SHALL be 0.
REQ-030 SHALL evaluate address range on the full 32 bits; upper address bits are never silently wrapped.

Reset
REQ-031 While reset=1 at a clock edge, SHALL enter IDLE and clear all registers; outputs after that edge: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, resp_err_cause=00, all mem_* =0.
REQ-032 Reset asserted during ACCESS SHALL suppress any further memwrite; a store whose ACCESS cycle coincides with the reset edge is not written.
REQ-033 A pending response SHALL be discarded by reset without requiring resp_ready.

Verification
REQ-034 Store then load: SW 0xDEADBEEF to addr 0x10, then LW addr 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid two cycles after each accept.
REQ-035 Byte/half extension: after SW 0x0000_80F0 to 0x20, LB 0x20 -> 0xFFFFFFF0; LBU 0x20 -> 0x000000F0; LH 0x20 -> 0xFFFF80F0; LHU 0x20 -> 0x000080F0.
REQ-036 Misaligned: LW at 0x22 -> resp_err=1, cause 01, mem_memread never asserted; SH at 0x21 -> cause 01 and the memory at 0x20..0x23 unchanged.
REQ-037 Range and illegal funct3: LW at 0x400 with MEM_BYTES=1024 -> cause 10; load with funct3=011 -> cause 11; store with funct3=100 -> cause 11.
REQ-038 Backpressure: hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stay stable and req_ready=0 throughout; one cycle after resp_ready=1, req_ready=1.
REQ-039 Reset mid-op: assert reset in the ACCESS cycle of SW 0x12345678 to 0x30 -> a subsequent LW 0x30 returns the prior value, and outputs match REQ-031.
